// File: rtl/cpu_pkg.sv
// Shared core definitions: fetch FSM states, instruction size and the RV32 base
// opcodes the decoder also uses.
package cpu_pkg;

    typedef enum logic [1:0] {
        RESET,
        RUN,
        HALT
    } fetch_state_t;

    localparam int unsigned ILEN_BYTES = 4;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/cpu_fetch_unit_fetch_queue.sv
// Prefetch FIFO holding {pc, instruction} pairs; head is read straight from
// registered storage so the consumer sees no combinational input path.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     s_clk_i,
    input  logic                     s_resetn_i,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_valid,
    output logic [WIDTH-1:0]         head_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        head_valid = count != '0;
        do_push    = push && !flush;
        do_pop     = pop && head_valid && !flush;
        head_data  = head_valid ? mem[rd_ptr] : '0;
    end

    always_ff @(posedge s_clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Upstream credit accounting must never let a push land on a full queue.
            assert (!(do_push && !do_pop && count == CW'(DEPTH)));
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_fetch_unit.sv
// Decoupled instruction fetch front-end: credit-limited sequential ibus fetches,
// fixed-latency response pipe, prefetch queue, redirect flush and misalign halt.
module cpu_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned RESP_LAT = 1
) (
    input  logic            s_clk_i,
    input  logic            s_resetn_i,
    input  logic [XLEN-1:0] s_boot_add_i,
    output logic            s_ibus_req_o,
    output logic [XLEN-1:0] s_ibus_add_o,
    input  logic [XLEN-1:0] s_ibus_val_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    input  logic            instr_ready_i,
    output logic            s_error_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(DEPTH);

    fetch_state_t        state;
    fetch_state_t        state_nxt;
    logic [XLEN-1:0]     fetch_pc;
    logic [RESP_LAT-1:0] pipe_vld;
    logic [XLEN-1:0]     pipe_pc [RESP_LAT];
    logic [CW-1:0]       q_count;
    logic [CW-1:0]       inflight;
    logic [CW:0]         credit_used;
    logic                issue;
    logic                flush;
    logic                misaligned;
    logic                push;
    logic                pop;
    logic                q_valid;
    logic [2*XLEN-1:0]   q_head;

    // Queued plus in-flight entries bound the requests so a response always has room.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RESP_LAT; i++) begin
            inflight = inflight + CW'(pipe_vld[i]);
        end
        credit_used = {1'b0, q_count} + {1'b0, inflight};
    end

    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        flush      = 1'b0;
        misaligned = redirect_i && !is_word_aligned(redirect_pc_i[1:0]);
        case (state)
            RESET: state_nxt = RUN;
            RUN: begin
                if (redirect_i) begin
                    flush = 1'b1;
                    if (misaligned) begin
                        state_nxt = HALT;
                    end
                end else if (credit_used < DEPTH_LIM) begin
                    issue = 1'b1;
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = RESET;
        endcase
    end

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            state     <= RESET;
            fetch_pc  <= s_boot_add_i;
            pipe_vld  <= '0;
            s_error_o <= 1'b0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                fetch_pc <= redirect_pc_i;
                if (misaligned) begin
                    s_error_o <= 1'b1;
                end
            end else if (issue) begin
                fetch_pc <= fetch_pc + XLEN'(ILEN_BYTES);
            end
            pipe_vld[0] <= issue;
            for (int unsigned i = 1; i < RESP_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1] && !flush;
            end
        end
    end

    always_ff @(posedge s_clk_i) begin
        pipe_pc[0] <= fetch_pc;
        for (int unsigned i = 1; i < RESP_LAT; i++) begin
            pipe_pc[i] <= pipe_pc[i-1];
        end
    end

    assign push = pipe_vld[RESP_LAT-1];
    assign pop  = instr_ready_i;

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_queue (
        .s_clk_i    (s_clk_i),
        .s_resetn_i (s_resetn_i),
        .push       (push),
        .push_data  ({pipe_pc[RESP_LAT-1], s_ibus_val_i}),
        .pop        (pop),
        .flush      (flush),
        .count      (q_count),
        .head_valid (q_valid),
        .head_data  (q_head)
    );

    assign s_ibus_req_o  = issue;
    assign s_ibus_add_o  = issue ? fetch_pc : '0;
    assign instr_valid_o = q_valid;
    assign instr_o       = q_head[XLEN-1:0];
    assign instr_pc_o    = q_head[2*XLEN-1:XLEN];

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Bench for cpu_fetch_unit: two instances (response latency 1 and 2) driven by the
// same stimulus and checked every cycle against a queue-level reference model.
module tb_cpu_fetch_unit;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] boot_add;
    logic        redirect;
    logic [31:0] rpc;
    logic        ready;
    logic [31:0] ibus_val [2];

    logic        d_req   [2];
    logic [31:0] d_add   [2];
    logic        d_valid [2];
    logic [31:0] d_instr [2];
    logic [31:0] d_pc    [2];
    logic        d_err   [2];

    logic        s_req   [2];
    logic [31:0] s_add   [2];
    logic        s_valid [2];
    logic [31:0] s_pc    [2];
    logic        s_err   [2];

    // reference model: 0 = held in reset/boot cycle, 1 = fetching, 2 = halted
    int          m_st    [2];
    logic [31:0] m_pc    [2];
    logic        m_err   [2];
    logic [31:0] q_pc    [2][8];
    int          q_n     [2];
    logic [31:0] f_pc    [2][8];
    int          f_rem   [2][8];
    int          f_n     [2];

    logic        h_v     [2][2];
    logic [31:0] h_a     [2][2];

    int ntests = 0;
    int nfail  = 0;
    int nreq   [2];

    always #5 clk = ~clk;

    cpu_fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESP_LAT(1)) dut_lat1 (
        .s_clk_i       (clk),
        .s_resetn_i    (rst_n),
        .s_boot_add_i  (boot_add),
        .s_ibus_req_o  (d_req[0]),
        .s_ibus_add_o  (d_add[0]),
        .s_ibus_val_i  (ibus_val[0]),
        .redirect_i    (redirect),
        .redirect_pc_i (rpc),
        .instr_valid_o (d_valid[0]),
        .instr_o       (d_instr[0]),
        .instr_pc_o    (d_pc[0]),
        .instr_ready_i (ready),
        .s_error_o     (d_err[0])
    );

    cpu_fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESP_LAT(2)) dut_lat2 (
        .s_clk_i       (clk),
        .s_resetn_i    (rst_n),
        .s_boot_add_i  (boot_add),
        .s_ibus_req_o  (d_req[1]),
        .s_ibus_add_o  (d_add[1]),
        .s_ibus_val_i  (ibus_val[1]),
        .redirect_i    (redirect),
        .redirect_pc_i (rpc),
        .instr_valid_o (d_valid[1]),
        .instr_o       (d_instr[1]),
        .instr_pc_o    (d_pc[1]),
        .instr_ready_i (ready),
        .s_error_o     (d_err[1])
    );

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ (a * 32'd3) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s dut%0d: observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset(input int k);
        m_st[k]  = 0;
        m_pc[k]  = boot_add;
        m_err[k] = 1'b0;
        q_n[k]   = 0;
        f_n[k]   = 0;
        h_v[k][0] = 1'b0;
        h_v[k][1] = 1'b0;
    endtask

    task automatic check_outputs(input int k);
        logic er;
        er = rst_n && m_st[k] == 1 && !redirect && (q_n[k] + f_n[k] < int'(DEPTH));
        s_req[k]   = d_req[k];
        s_add[k]   = d_add[k];
        s_valid[k] = d_valid[k];
        s_pc[k]    = d_pc[k];
        s_err[k]   = d_err[k];
        chk("req", k, 32'(d_req[k]), 32'(er));
        if (er) chk("addr", k, d_add[k], m_pc[k]);
        chk("valid", k, 32'(d_valid[k]), 32'(q_n[k] > 0));
        if (q_n[k] > 0) begin
            chk("head_pc", k, d_pc[k], q_pc[k][0]);
            chk("head_instr", k, d_instr[k], word(q_pc[k][0]));
        end
        chk("error", k, 32'(d_err[k]), 32'(m_err[k]));
        if (!rst_n) begin
            chk("rst_addr", k, d_add[k], 32'h0);
            chk("rst_pc", k, d_pc[k], 32'h0);
            chk("rst_instr", k, d_instr[k], 32'h0);
        end
    endtask

    task automatic model_edge(input int k);
        logic req;
        int   keep;
        if (!rst_n) begin
            model_reset(k);
            return;
        end
        if (m_st[k] == 0) begin
            m_st[k] = 1;
        end else if (m_st[k] == 1) begin
            if (redirect) begin
                q_n[k] = 0;
                f_n[k] = 0;
                if (rpc[1:0] != 2'b00) begin
                    m_err[k] = 1'b1;
                    m_st[k]  = 2;
                end else begin
                    m_pc[k] = rpc;
                end
            end else begin
                req = q_n[k] + f_n[k] < int'(DEPTH);
                if (q_n[k] > 0 && ready) begin
                    for (int i = 0; i < 7; i++) q_pc[k][i] = q_pc[k][i+1];
                    q_n[k]--;
                end
                keep = 0;
                for (int i = 0; i < f_n[k]; i++) begin
                    if (f_rem[k][i] == 1) begin
                        q_pc[k][q_n[k]] = f_pc[k][i];
                        q_n[k]++;
                    end else begin
                        f_pc[k][keep]  = f_pc[k][i];
                        f_rem[k][keep] = f_rem[k][i] - 1;
                        keep++;
                    end
                end
                f_n[k] = keep;
                if (req) begin
                    f_pc[k][f_n[k]]  = m_pc[k];
                    f_rem[k][f_n[k]] = lat(k);
                    f_n[k]++;
                    m_pc[k] = m_pc[k] + 32'd4;
                end
            end
        end
    endtask

    // One clock: check at negedge, advance model/bus at posedge, drive at posedge+1.
    task automatic cycle();
        @(negedge clk);
        for (int k = 0; k < 2; k++) check_outputs(k);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            model_edge(k);
            h_v[k][1] = h_v[k][0];
            h_a[k][1] = h_a[k][0];
            h_v[k][0] = rst_n && s_req[k];
            h_a[k][0] = s_add[k];
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            ibus_val[k] = h_v[k][lat(k)-1] ? word(h_a[k][lat(k)-1]) : $urandom;
        end
    endtask

    task automatic mid_reset(input logic [31:0] boot);
        #2;
        rst_n    = 1'b0;
        boot_add = boot;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("async_req", k, 32'(d_req[k]), 32'h0);
            chk("async_valid", k, 32'(d_valid[k]), 32'h0);
            chk("async_err", k, 32'(d_err[k]), 32'h0);
            chk("async_pc", k, d_pc[k], 32'h0);
            model_reset(k);
        end
    endtask

    initial begin
        rst_n       = 1'b1;
        boot_add    = 32'h1000;
        redirect    = 1'b0;
        rpc         = 32'h0;
        ready       = 1'b1;
        ibus_val[0] = 32'h0;
        ibus_val[1] = 32'h0;
        #1;
        rst_n = 1'b0;
        model_reset(0);
        model_reset(1);
        repeat (2) cycle();

        // boot stream at 0x1000
        rst_n = 1'b1;
        cycle();
        cycle();
        for (int k = 0; k < 2; k++) begin
            chk("t1_req", k, 32'(s_req[k]), 32'h1);
            chk("t1_addr", k, s_add[k], 32'h1000);
        end
        cycle();
        cycle();
        chk("t1_first_valid", 0, 32'(s_valid[0]), 32'h1);
        chk("t1_first_pc", 0, s_pc[0], 32'h1000);
        cycle();
        chk("t1_second_pc", 0, s_pc[0], 32'h1004);
        repeat (12) cycle();

        // redirect with responses in flight
        redirect = 1'b1;
        rpc      = 32'h2000;
        cycle();
        redirect = 1'b0;
        cycle();
        for (int k = 0; k < 2; k++) chk("t3_addr", k, s_add[k], 32'h2000);
        cycle();
        cycle();
        chk("t3_lat1_pc", 0, s_pc[0], 32'h2000);
        chk("t3_lat2_early", 1, 32'(s_valid[1]), 32'h0);
        cycle();
        chk("t3_lat2_valid", 1, 32'(s_valid[1]), 32'h1);
        chk("t3_lat2_pc", 1, s_pc[1], 32'h2000);

        // random consumer stalls and aligned redirects
        repeat (300) begin
            ready    = $urandom_range(0, 9) < 7;
            redirect = $urandom_range(0, 19) == 0;
            rpc      = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            cycle();
        end
        redirect = 1'b0;
        ready    = 1'b1;

        // address wrap
        redirect = 1'b1;
        rpc      = 32'hFFFF_FFFC;
        cycle();
        redirect = 1'b0;
        cycle();
        for (int k = 0; k < 2; k++) chk("wrap_last", k, s_add[k], 32'hFFFF_FFFC);
        cycle();
        for (int k = 0; k < 2; k++) begin
            chk("wrap_req", k, 32'(s_req[k]), 32'h1);
            chk("wrap_zero", k, s_add[k], 32'h0);
        end
        repeat (6) cycle();

        // reset mid-stream, then credit limit with a stalled consumer
        mid_reset(32'h4000);
        repeat (2) cycle();
        ready = 1'b0;
        rst_n = 1'b1;
        cycle();
        nreq[0] = 0;
        nreq[1] = 0;
        for (int i = 0; i < 13; i++) begin
            cycle();
            if (i == 0) begin
                for (int k = 0; k < 2; k++) chk("boot_addr", k, s_add[k], 32'h4000);
            end
            for (int k = 0; k < 2; k++) nreq[k] += s_req[k] ? 1 : 0;
        end
        for (int k = 0; k < 2; k++) chk("credit_reqs", k, nreq[k], DEPTH);
        ready = 1'b1;
        repeat (8) cycle();

        // misaligned redirect halts until reset
        redirect = 1'b1;
        rpc      = 32'h2002;
        cycle();
        redirect = 1'b0;
        cycle();
        for (int k = 0; k < 2; k++) begin
            chk("halt_err", k, 32'(s_err[k]), 32'h1);
            chk("halt_req", k, 32'(s_req[k]), 32'h0);
        end
        repeat (8) cycle();
        mid_reset(32'h1000);
        cycle();
        for (int k = 0; k < 2; k++) chk("err_cleared", k, 32'(s_err[k]), 32'h0);
        rst_n = 1'b1;
        repeat (6) cycle();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
